// File: rtl/axis_traffic_gen_if.sv
// axis_traffic_gen_if: bundles the AXI-Lite control port and the AXI-Stream
// output of the traffic generator.
//   slave  modport: the generator side (AXI-Lite slave, stream source).
//   master modport: the host side (AXI-Lite master, stream sink).
// Signals keep their s_axi_control_* / outstream_* names from the block
// design so the wiring reads the same as the packaged kernel.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface axis_traffic_gen_if #(
    parameter int unsigned DATA_BYTES = `DATA_WIDTH
);
    logic                      s_axi_control_awvalid;
    logic                      s_axi_control_awready;
    logic [15:0]               s_axi_control_awaddr;
    logic                      s_axi_control_wvalid;
    logic                      s_axi_control_wready;
    logic [31:0]               s_axi_control_wdata;
    logic [3:0]                s_axi_control_wstrb;
    logic                      s_axi_control_bvalid;
    logic                      s_axi_control_bready;
    logic [1:0]                s_axi_control_bresp;
    logic                      s_axi_control_arvalid;
    logic                      s_axi_control_arready;
    logic [15:0]               s_axi_control_araddr;
    logic                      s_axi_control_rvalid;
    logic                      s_axi_control_rready;
    logic [31:0]               s_axi_control_rdata;
    logic [1:0]                s_axi_control_rresp;
    logic [DATA_BYTES*8-1:0]   outstream_tdata;
    logic                      outstream_tvalid;
    logic                      outstream_tready;

    modport slave (
        input  s_axi_control_awvalid, s_axi_control_awaddr,
        output s_axi_control_awready,
        input  s_axi_control_wvalid, s_axi_control_wdata, s_axi_control_wstrb,
        output s_axi_control_wready,
        output s_axi_control_bvalid, s_axi_control_bresp,
        input  s_axi_control_bready,
        input  s_axi_control_arvalid, s_axi_control_araddr,
        output s_axi_control_arready,
        output s_axi_control_rvalid, s_axi_control_rdata, s_axi_control_rresp,
        input  s_axi_control_rready,
        output outstream_tdata, outstream_tvalid,
        input  outstream_tready
    );

    modport master (
        output s_axi_control_awvalid, s_axi_control_awaddr,
        input  s_axi_control_awready,
        output s_axi_control_wvalid, s_axi_control_wdata, s_axi_control_wstrb,
        input  s_axi_control_wready,
        input  s_axi_control_bvalid, s_axi_control_bresp,
        output s_axi_control_bready,
        output s_axi_control_arvalid, s_axi_control_araddr,
        input  s_axi_control_arready,
        input  s_axi_control_rvalid, s_axi_control_rdata, s_axi_control_rresp,
        output s_axi_control_rready,
        input  outstream_tdata, outstream_tvalid,
        output outstream_tready
    );
endinterface

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Lite controlled AXI-Stream beat generator.
// A run emits BEATS beats whose payload is the running beat index, with GAP
// idle cycles inserted after each accepted beat. A run can be aborted; the
// beat already on the bus is still completed.
// Ports:
//   ap_clk - clock, rising edge
//   ap_rst - synchronous active-high reset
//   bus    - axis_traffic_gen_if.slave (AXI-Lite control + outstream)
// Registers: 0x10 CONTROL (W, bit0 START, bit1 ABORT), 0x14 BEATS, 0x18 GAP,
//            0x1C STATUS (bit0 BUSY, bit1 DONE), 0x20 SENT. Unmapped reads
//            return 32'h0000DEAD.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module axis_traffic_gen #(
    parameter int unsigned DATA_BYTES = `DATA_WIDTH
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    axis_traffic_gen_if.slave   bus
);
    localparam int unsigned TW = DATA_BYTES * 8;

    localparam logic [15:0] ADDR_CONTROL = 16'h0010;
    localparam logic [15:0] ADDR_BEATS   = 16'h0014;
    localparam logic [15:0] ADDR_GAP     = 16'h0018;
    localparam logic [15:0] ADDR_STATUS  = 16'h001C;
    localparam logic [15:0] ADDR_SENT    = 16'h0020;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    // AXI-Lite state
    logic        aw_held_q;
    logic [15:0] aw_addr_q;
    logic        w_held_q;
    logic [31:0] w_data_q;
    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // Generator state
    state_e          state_q;
    logic [31:0]     beats_q;
    logic [31:0]     gap_q;
    logic [31:0]     sent_q;
    logic [31:0]     gap_cnt_q;
    logic            abort_q;
    logic            tvalid_q;
    logic [TW-1:0]   tdata_q;

    logic        aw_ready, w_ready, ar_ready;
    logic        aw_fire, w_fire, ar_fire;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        ctrl_wr, start_req, abort_req;
    logic [31:0] sent_inc;
    logic [31:0] rd_mux;
    logic        unused_wstrb;

    always_comb begin
        aw_ready  = !aw_held_q && !bvalid_q;
        w_ready   = !w_held_q && !bvalid_q;
        ar_ready  = !rvalid_q;
        aw_fire   = bus.s_axi_control_awvalid && aw_ready;
        w_fire    = bus.s_axi_control_wvalid && w_ready;
        ar_fire   = bus.s_axi_control_arvalid && ar_ready;
        // A channel arriving this cycle pairs with one captured earlier.
        wr_addr   = aw_held_q ? aw_addr_q : bus.s_axi_control_awaddr;
        wr_data   = w_held_q ? w_data_q : bus.s_axi_control_wdata;
        wr_en     = (aw_held_q || aw_fire) && (w_held_q || w_fire);
        busy      = (state_q == StSend) || (state_q == StGap);
        ctrl_wr   = wr_en && (wr_addr == ADDR_CONTROL);
        // ABORT wins over START when both bits are set.
        abort_req = ctrl_wr && wr_data[1];
        start_req = ctrl_wr && wr_data[0] && !wr_data[1];
        sent_inc  = sent_q + 32'd1;

        rd_mux = 32'h0000_DEAD;
        unique case (bus.s_axi_control_araddr)
            ADDR_CONTROL: rd_mux = 32'h0;
            ADDR_BEATS:   rd_mux = beats_q;
            ADDR_GAP:     rd_mux = gap_q;
            ADDR_STATUS:  rd_mux = {30'h0, state_q == StDone, busy};
            ADDR_SENT:    rd_mux = sent_q;
            default:      rd_mux = 32'h0000_DEAD;
        endcase
    end

    assign unused_wstrb = ^bus.s_axi_control_wstrb;

    // AXI-Lite write/read channels and the R/W configuration registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            beats_q   <= '0;
            gap_q     <= '0;
        end else begin
            if (wr_en) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                // Configuration is frozen for the duration of a run.
                if (!busy) begin
                    if (wr_addr == ADDR_BEATS) beats_q <= wr_data;
                    if (wr_addr == ADDR_GAP)   gap_q   <= wr_data;
                end
            end else begin
                if (aw_fire) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= bus.s_axi_control_awaddr;
                end
                if (w_fire) begin
                    w_held_q <= 1'b1;
                    w_data_q <= bus.s_axi_control_wdata;
                end
                if (bvalid_q && bus.s_axi_control_bready) bvalid_q <= 1'b0;
            end

            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && bus.s_axi_control_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Run FSM with registered stream outputs
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= StIdle;
            sent_q    <= '0;
            gap_cnt_q <= '0;
            abort_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_req) begin
                        sent_q <= '0;
                        if (beats_q != 32'd0) begin
                            state_q  <= StSend;
                            tvalid_q <= 1'b1;
                            tdata_q  <= '0;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StSend: begin
                    if (tvalid_q && bus.outstream_tready) begin
                        sent_q <= sent_inc;
                        if (abort_q || abort_req || (sent_inc == beats_q)) begin
                            state_q  <= StDone;
                            tvalid_q <= 1'b0;
                            abort_q  <= 1'b0;
                        end else if (gap_q == 32'd0) begin
                            tdata_q <= TW'(sent_inc);
                        end else begin
                            state_q   <= StGap;
                            tvalid_q  <= 1'b0;
                            gap_cnt_q <= gap_q;
                        end
                    end else if (abort_req) begin
                        // Remember the abort; the pending beat must still go out.
                        abort_q <= 1'b1;
                    end
                end
                StGap: begin
                    if (abort_req) begin
                        state_q <= StDone;
                    end else if (gap_cnt_q <= 32'd1) begin
                        state_q  <= StSend;
                        tvalid_q <= 1'b1;
                        tdata_q  <= TW'(sent_q);
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.s_axi_control_awready = aw_ready;
    assign bus.s_axi_control_wready  = w_ready;
    assign bus.s_axi_control_bvalid  = bvalid_q;
    assign bus.s_axi_control_bresp   = 2'b00;
    assign bus.s_axi_control_arready = ar_ready;
    assign bus.s_axi_control_rvalid  = rvalid_q;
    assign bus.s_axi_control_rdata   = rdata_q;
    assign bus.s_axi_control_rresp   = 2'b00;
    assign bus.outstream_tdata       = tdata_q;
    assign bus.outstream_tvalid      = tvalid_q;

endmodule

// File: doc/axis_traffic_gen.md
AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 Parameter DATA_BYTES, default `DATA_WIDTH (from axis_measure_defs.vh): outstream beat width in bytes.
REQ-002 ap_clk  in  1  sole clock; all logic on the rising edge.
REQ-003 ap_rst  in  1  reset, synchronous and active-high.
REQ-004 s_axi_control_awvalid/awready  in/out  1/1  AXI-Lite write address handshake.
REQ-005 s_axi_control_awaddr  in  16  byte write address.
REQ-006 s_axi_control_wvalid/wready  in/out  1/1  AXI-Lite write data handshake.
REQ-007 s_axi_control_wdata/wstrb  in  32/4  write data and strobes; wstrb is ignored, and full words are written.
REQ-008 s_axi_control_bvalid/bready/bresp  out/in/out  1/1/2  write response; bresp is always 2'b00.
REQ-009 s_axi_control_arvalid/arready/araddr  in/out/in  1/1/16  read address handshake.
REQ-010 s_axi_control_rvalid/rready/rdata/rresp  out/in/out/out  1/1/32/2  read data; rresp is always 2'b00.
REQ-011 outstream_tdata  out  DATA_BYTES*8  generated beat, feeding axis_measure_top instream.
REQ-012 outstream_tvalid/outstream_tready  out/in  1/1  AXI-Stream handshake.

Function
REQ-013 Register map (byte offsets):
- 0x10 CONTROL (W): bit0 START, bit1 ABORT; self-clearing; reads return 0.
- 0x14 BEATS (R/W): number of beats per run.
- 0x18 GAP (R/W): idle cycles after each accepted beat.
- 0x1C STATUS (R): bit0 BUSY, bit1 DONE.
- 0x20 SENT (R): beats accepted in the current or last run.
REQ-014 Reads of any unmapped address SHALL return 32'h0000DEAD with OKAY.
REQ-015 Write address and write data SHALL be accepted in either order or together; the register write occurs on the cycle both are held; bvalid rises the next cycle and stays high until bready.
REQ-016 awready and wready SHALL be low while their channel is already captured and awaiting its partner, or while bvalid is high.
REQ-017 arready SHALL be low while rvalid is high; rdata is registered, rvalid rises 1 cycle after the AR handshake and holds until rready.
REQ-018 FSM states: IDLE, SEND, GAP, DONE.
REQ-019 IDLE/DONE, START written: SENT is cleared and DONE is cleared; the FSM goes to SEND next cycle if BEATS!=0, otherwise to DONE next cycle with no beat emitted.
REQ-020 SEND: tvalid=1 and tdata=SENT zero-extended to DATA_BYTES*8; tdata/tvalid hold stable until tready.
REQ-021 On a handshake, SENT increments (wrapping at 2^32):
- reaching BEATS -> DONE;
- otherwise GAP=0 -> stay in SEND (back-to-back beats, tvalid continuously high);
- otherwise -> GAP.
REQ-022 GAP: tvalid=0 for exactly GAP cycles, then SEND.
REQ-023 ABORT while in SEND with a pending beat: the pending beat is still completed, then the FSM goes to DONE; ABORT in GAP goes to DONE next cycle; ABORT in IDLE/DONE has no effect.
REQ-024 START while BUSY (SEND or GAP) SHALL be ignored; BEATS/GAP writes while BUSY are acknowledged OKAY but leave the values unchanged.
REQ-025 BUSY=1 in SEND or GAP; DONE=1 in DONE state only.
REQ-026 A simultaneous START and ABORT in one write SHALL be treated as ABORT only.

Reset
REQ-027 On ap_rst=1 at a clock edge, the following SHALL be cleared: FSM=IDLE; BEATS=0, GAP=0, SENT=0; tvalid=0, tdata=0; bvalid=0, rvalid=0, rdata=0; all pending AW/W captures dropped.
REQ-028 Reset mid-run SHALL deassert tvalid on the next cycle, even without a handshake; no response is issued for in-flight AXI-Lite transactions.

Verification
REQ-029 BEATS=4, GAP=0, tready=1, START -> beats with tdata 0,1,2,3 on 4 consecutive cycles; then STATUS=0x2 and SENT=4.
REQ-030 BEATS=3, GAP=2, tready=1 -> tvalid pattern 1,0,0,1,0,0,1, then DONE.
REQ-031 BEATS=2, tready=0 for 5 cycles then 1 -> tdata=0 and tvalid=1 held stable for all 5 stalled cycles; 2 beats total.
REQ-032 BEATS=0, START -> no tvalid ever; STATUS=0x2 one cycle later.
REQ-033 BEATS=100, ABORT after 10 beats while tready=0 -> beat 10 completes when tready rises; DONE follows, and SENT=11.
REQ-034 W written 3 cycles before AW to 0x14 with value 7 -> BEATS reads 7; exactly one bvalid pulse; a read of 0x40 returns 0x0000DEAD.
